// File: rtl/subsample_8x8.sv
`default_nettype none
// ============================================================================
//  Module   : subsample_8x8
//  Purpose  : Chroma 4:2:0 subsampler. Collects four 8x8 chroma quadrants of
//             one 16x16 MCU, averages every 2x2 neighbourhood with round-half-
//             up, and emits one 8x8 block with a single-cycle valid pulse.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef CH
`define CH 2
`endif

module subsample_8x8 (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [$clog2(`CH+1)-1:0]           ch,
  input  logic                               valid_in,
  input  logic signed [7:0][7:0][8:0]        block_in,
  output logic signed [7:0][7:0][8:0]        block_out,
  output logic [$clog2(`CH+1)-1:0]           ch_out,
  output logic                               valid_out,
  output logic                               busy
);

  localparam int CH_W = $clog2(`CH+1);
  localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
  localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

  // Quadrant index doubles as the collection state: Q0 is idle.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  quad_e                       state_q, state_d;
  logic [CH_W-1:0]             grp_ch_q, grp_ch_d;
  logic [2:0][3:0][3:0][8:0]   buf_q, buf_d;
  logic [7:0][7:0][8:0]        block_out_q, block_out_d;
  logic [CH_W-1:0]             ch_out_q, ch_out_d;
  logic                        valid_out_q, valid_out_d;
  logic                        busy_q, busy_d;

  logic [3:0][3:0][8:0]        avg_w;
  logic                        is_chroma_w;
  logic                        same_grp_w;
  logic [1:0]                  quad_idx_w;

  // Sum four samples in 11 bits; the arithmetic shift makes exact halves
  // round toward +inf. The result always fits 9 bits signed.
  function automatic logic [8:0] avg4(input logic signed [8:0] a,
                                      input logic signed [8:0] b,
                                      input logic signed [8:0] c,
                                      input logic signed [8:0] d);
    logic signed [10:0] s;
    s = 11'(a) + 11'(b) + 11'(c) + 11'(d) + 11'sd2;
    return 9'(s >>> 2);
  endfunction

  // 4x4 average of the incoming block, ready for whichever quadrant it is.
  always_comb begin
    avg_w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        avg_w[r][c] = avg4($signed(block_in[2*r][2*c]),
                           $signed(block_in[2*r][2*c+1]),
                           $signed(block_in[2*r+1][2*c]),
                           $signed(block_in[2*r+1][2*c+1]));
      end
    end
  end

  // Channel classification of the incoming block against the open group.
  always_comb begin
    is_chroma_w = (ch == CH_CB) || (ch == CH_CR);
    same_grp_w  = (state_q != Q0) && (ch == grp_ch_q);
    quad_idx_w  = state_q;
  end

  // Quadrant sequencing, buffer fill and output load on the final quadrant.
  always_comb begin
    state_d     = state_q;
    grp_ch_d    = grp_ch_q;
    buf_d       = buf_q;
    block_out_d = block_out_q;
    ch_out_d    = ch_out_q;
    valid_out_d = 1'b0;

    if (valid_in) begin
      if (!is_chroma_w) begin
        // Luma or unknown id: drop the block and any partial group.
        state_d = Q0;
      end else if (!same_grp_w) begin
        // Idle, or a channel change that discards the partial group:
        // this block opens a new group as quadrant 0.
        grp_ch_d = ch;
        buf_d[0] = avg_w;
        state_d  = Q1;
      end else if (state_q == Q3) begin
        // Final quadrant: publish buffered quadrants plus this one at once,
        // leaving the buffer free for the next group.
        for (int qd = 0; qd < 3; qd++) begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
              block_out_d[(qd/2)*4 + r][(qd%2)*4 + c] = buf_q[qd][r][c];
            end
          end
        end
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            block_out_d[4 + r][4 + c] = avg_w[r][c];
          end
        end
        ch_out_d    = grp_ch_q;
        valid_out_d = 1'b1;
        state_d     = Q0;
      end else begin
        buf_d[quad_idx_w] = avg_w;
        state_d           = (state_q == Q1) ? Q2 : Q3;
      end
    end

    busy_d = (state_d != Q0);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= Q0;
      grp_ch_q    <= '0;
      buf_q       <= '0;
      block_out_q <= '0;
      ch_out_q    <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_ch_q    <= grp_ch_d;
      buf_q       <= buf_d;
      block_out_q <= block_out_d;
      ch_out_q    <= ch_out_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
    end
  end

  assign block_out = block_out_q;
  assign ch_out    = ch_out_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_subsample_8x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subsample_8x8
//  Purpose  : Directed self-checking bench for subsample_8x8.
//  Revision : 1.0  initial release
// ============================================================================

module tb_subsample_8x8;

  typedef logic [7:0][7:0][8:0] blk_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  ch = 2'b00;
  blk_t        block_in = '0;
  blk_t        block_out;
  logic [1:0]  ch_out;
  logic        valid_out;
  logic        busy;

  int total  = 0;
  int bad    = 0;
  int vcount = 0;
  int v0     = 0;
  blk_t rnd;
  blk_t exp_rnd;

  subsample_8x8 dut (
    .clock     (clock),
    .reset     (reset),
    .ch        (ch),
    .valid_in  (valid_in),
    .block_in  (block_in),
    .block_out (block_out),
    .ch_out    (ch_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Count valid_out pulses, sampled on the inactive edge.
  always @(negedge clock) if (valid_out === 1'b1) vcount++;

  function automatic blk_t fill(input int v);
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = 9'(v);
    return b;
  endfunction

  function automatic blk_t quads(input int a, input int b, input int c, input int d);
    blk_t o;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        o[r][k] = (r < 4) ? ((k < 4) ? 9'(a) : 9'(b)) : ((k < 4) ? 9'(c) : 9'(d));
    return o;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_blk(input string tag, input blk_t obs, input blk_t expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [1:0] cc, input blk_t b);
    ch       = cc;
    block_in = b;
    valid_in = 1'b1;
    @(posedge clock);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // ---- Reset held with toggling random input ----
    repeat (6) begin
      valid_in = ~valid_in;
      ch       = 2'($urandom_range(0, 3));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          block_in[r][c] = 9'($urandom_range(0, 511));
      @(posedge clock);
      #1;
    end
    chk_blk("reset_block_out", block_out, '0);
    chk("reset_ch_out", ch_out, 0);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_no_pulse", vcount, 0);
    valid_in = 1'b0;
    reset    = 1'b1;
    idle(1);

    // ---- Constant quadrants, Cb ----
    v0 = vcount;
    send(2'b01, fill(10));
    chk("const_busy_q1", busy, 1);
    send(2'b01, fill(20));
    send(2'b01, fill(30));
    chk("const_no_early_valid", valid_out, 0);
    send(2'b01, fill(40));
    chk("const_valid", valid_out, 1);
    chk("const_ch_out", ch_out, 1);
    chk_blk("const_block", block_out, quads(10, 20, 30, 40));
    chk("const_busy_done", busy, 0);
    idle(1);
    chk("const_valid_drop", valid_out, 0);
    chk("const_pulses", vcount - v0, 1);

    // ---- Rounding patches in quadrants 0 and 3 ----
    rnd = '0;
    rnd[0][0] = 9'h001; rnd[0][1] = 9'h002; rnd[1][0] = 9'h003; rnd[1][1] = 9'h004;
    rnd[0][2] = 9'h1FF; rnd[0][3] = 9'h1FE; rnd[1][2] = 9'h1FE; rnd[1][3] = 9'h1FE;
    rnd[0][4] = 9'h1FF; rnd[0][5] = 9'h1FF; rnd[1][4] = 9'h1FE; rnd[1][5] = 9'h1FE;
    rnd[0][6] = 9'h0FF; rnd[0][7] = 9'h0FF; rnd[1][6] = 9'h0FF; rnd[1][7] = 9'h0FE;
    rnd[2][0] = 9'h100; rnd[2][1] = 9'h100; rnd[3][0] = 9'h100; rnd[3][1] = 9'h100;
    exp_rnd = '0;
    exp_rnd[0][0] = 9'h003; exp_rnd[0][1] = 9'h1FE; exp_rnd[0][2] = 9'h1FF;
    exp_rnd[0][3] = 9'h0FF; exp_rnd[1][0] = 9'h100;
    exp_rnd[4][4] = 9'h003; exp_rnd[4][5] = 9'h1FE; exp_rnd[4][6] = 9'h1FF;
    exp_rnd[4][7] = 9'h0FF; exp_rnd[5][4] = 9'h100;
    send(2'b01, rnd);
    send(2'b01, fill(0));
    send(2'b01, fill(0));
    send(2'b01, rnd);
    chk("rnd_valid", valid_out, 1);
    chk("rnd_1234", $signed(block_out[0][0]), 3);
    chk("rnd_m1m2m2m2", $signed(block_out[0][1]), -2);
    chk("rnd_m1m1m2m2", $signed(block_out[0][2]), -1);
    chk("rnd_255x3_254", $signed(block_out[0][3]), 255);
    chk("rnd_m256x4", $signed(block_out[1][0]), -256);
    chk("rnd_q3_m256x4", $signed(block_out[5][4]), -256);
    chk_blk("rnd_block", block_out, exp_rnd);
    idle(1);

    // ---- Back-to-back Cr groups with a gap inside group 2 ----
    v0 = vcount;
    send(2'b10, fill(5));
    send(2'b10, fill(6));
    send(2'b10, fill(7));
    send(2'b10, fill(8));
    chk("b2b_g1_valid", valid_out, 1);
    chk("b2b_g1_ch", ch_out, 2);
    chk_blk("b2b_g1_block", block_out, quads(5, 6, 7, 8));
    send(2'b10, fill(-3));
    chk("b2b_g1_pulse_once", valid_out, 0);
    send(2'b10, fill(-50));
    idle(3);
    chk("b2b_gap_busy", busy, 1);
    chk("b2b_gap_valid", valid_out, 0);
    chk_blk("b2b_hold", block_out, quads(5, 6, 7, 8));
    send(2'b10, fill(100));
    chk_blk("b2b_hold_q2", block_out, quads(5, 6, 7, 8));
    send(2'b10, fill(-128));
    chk("b2b_g2_valid", valid_out, 1);
    chk_blk("b2b_g2_block", block_out, quads(-3, -50, 100, -128));
    idle(1);
    chk("b2b_pulses", vcount - v0, 2);

    // ---- Channel switch mid-group ----
    v0 = vcount;
    send(2'b01, fill(77));
    send(2'b01, fill(88));
    send(2'b10, fill(11));
    send(2'b10, fill(12));
    send(2'b10, fill(13));
    chk("sw_no_valid", valid_out, 0);
    send(2'b10, fill(14));
    chk("sw_valid", valid_out, 1);
    chk("sw_ch_out", ch_out, 2);
    chk_blk("sw_block", block_out, quads(11, 12, 13, 14));
    idle(1);
    chk("sw_pulses", vcount - v0, 1);

    // ---- Luma abort ----
    v0 = vcount;
    send(2'b01, fill(50));
    send(2'b01, fill(60));
    send(2'b01, fill(70));
    chk("luma_busy_before", busy, 1);
    send(2'b00, fill(99));
    chk("luma_busy_drop", busy, 0);
    send(2'b11, fill(98));
    chk("nonchroma_idle", busy, 0);
    send(2'b01, fill(21));
    send(2'b01, fill(22));
    send(2'b01, fill(23));
    send(2'b01, fill(24));
    chk("luma_valid", valid_out, 1);
    chk("luma_ch_out", ch_out, 1);
    chk_blk("luma_block", block_out, quads(21, 22, 23, 24));
    idle(1);
    chk("luma_pulses", vcount - v0, 1);

    // ---- Asynchronous reset mid-group ----
    send(2'b10, fill(33));
    send(2'b10, fill(44));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ch_out", ch_out, 0);
    chk_blk("mid_rst_block", block_out, '0);
    @(posedge clock);
    #1 reset = 1'b1;
    v0 = vcount;
    send(2'b10, fill(1));
    send(2'b10, fill(2));
    send(2'b10, fill(3));
    chk("post_rst_no_valid", valid_out, 0);
    send(2'b10, fill(4));
    chk("post_rst_valid", valid_out, 1);
    chk_blk("post_rst_block", block_out, quads(1, 2, 3, 4));
    idle(1);
    chk("post_rst_pulses", vcount - v0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
